// File: rtl/shift_unit_iter.sv
// Iterative shift unit: SLL / SRL / SRA / ROTR by a variable amount, STEP bits per cycle.
// Latency: 1 cycle for shamt=0, otherwise ceil(shamt/STEP)+1 cycles from the accepting edge to done.
// Backpressure: start is ignored while busy (no queuing); a start in the done cycle is accepted.
module shift_unit_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  // STEP <= WIDTH/2, so it always fits in a shift-amount field.
  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         mode_reg;

  logic               accept;
  logic               last_step;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0] rot_pair;

  // Step size for this cycle: a full STEP, or whatever remains if less, so the
  // final step never over-shifts.
  always_comb begin
    k         = (rem < STEP_K) ? rem : STEP_K;
    last_step = (rem <= STEP_K);
  end

  // One partial shift of the working register by k in the captured mode.
  // SRA relies on the working MSB never changing, so it keeps replicating the
  // original operand sign bit on every step.
  always_comb begin
    shifted  = work;
    rot_pair = {work, work} >> k;
    case (mode_reg)
      MODE_SLL:  shifted = work << k;
      MODE_SRL:  shifted = work >> k;
      MODE_SRA:  shifted = $unsigned($signed(work) >>> k);
      MODE_ROTR: shifted = rot_pair[WIDTH-1:0];
      default:   shifted = work;
    endcase
  end

  // Next-state logic; IDLE and DONE both accept a new request.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (shamt == '0) ? S_DONE : S_BUSY;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, iterative shifting and result update on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      rem      <= '0;
      mode_reg <= MODE_SLL;
      result   <= '0;
    end else if (accept) begin
      work     <= data;
      rem      <= shamt;
      mode_reg <= mode;
      if (shamt == '0) begin
        result <= data;
      end
    end else if (state == S_BUSY) begin
      work <= shifted;
      rem  <= rem - k;
      if (last_step) begin
        result <= shifted;
      end
    end
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule
